// File: rtl/systolic_skew_feeder.sv
// West-edge feeder. It buffers one tile of A-column beats, then streams the tile into the PE rows with lane i delayed by i cycles.
// Defining SKEW_FEEDER_TILE_CNT_EN adds the tile_count and last_k status outputs.
module systolic_skew_feeder #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int K_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DW-1:0]              in_data,
  input  logic                         in_last,
  output logic [N*DW-1:0]              row_out,
  output logic [N-1:0]                 lane_valid,
  output logic                         busy,
  output logic                         tile_done
`ifdef SKEW_FEEDER_TILE_CNT_EN
  ,
  output logic [15:0]                  tile_count,
  output logic [$clog2(K_MAX+1)-1:0]   last_k
`endif
);

  localparam int PW  = $clog2(K_MAX + 1);
  localparam int AW  = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr, k_reg;
  logic [DCW-1:0]    drain_cnt;
  logic [N*DW-1:0]   mem [K_MAX];
  logic              accept, close_tile, stream_end, drain_end, done_nxt, push_v;
  logic [N*DW-1:0]   push_data;

  // Handshake: a beat transfers on a rising clk when in_valid & in_ready; while
  // in_ready is 0 the upstream must hold its beat, and in_last only counts on a transfer.
  assign in_ready   = (state == IDLE) | ((state == FILL) & (wr_ptr < PW'(K_MAX)));
  assign busy       = (state != IDLE);
  assign accept     = in_valid & in_ready;
  // The beat landing in the last buffer slot closes the tile even without in_last.
  assign close_tile = accept & (in_last | (wr_ptr == PW'(K_MAX - 1)));
  assign stream_end = (rd_ptr == k_reg - PW'(1));
  assign drain_end  = (drain_cnt == DCW'(N - 1));
  assign done_nxt   = (state == DRAIN) & drain_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = close_tile ? STREAM : FILL;
      FILL:    if (close_tile) state_nxt = STREAM;
      STREAM:  if (stream_end) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      k_reg     <= '0;
      drain_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= done_nxt;
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (close_tile) begin
          k_reg  <= wr_ptr + PW'(1);
          rd_ptr <= '0;
        end
      end
      if (state == STREAM) rd_ptr <= rd_ptr + PW'(1);
      if (state == DRAIN) begin
        drain_cnt <= drain_end ? '0 : drain_cnt + DCW'(1);
        if (drain_end) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
      end
    end
  end

  // Tile storage needs no reset: a reset only clears the pointers that qualify it.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  assign push_v    = (state == STREAM);
  assign push_data = push_v ? mem[rd_ptr[AW-1:0]] : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] feed_d, out_d;
    logic          feed_v, out_v;

    if (i == 0) begin : g_nodly
      assign feed_d = push_data[DW-1:0];
      assign feed_v = push_v;
    end else begin : g_dly
      logic [DW-1:0] sd [i];
      logic [i-1:0]  sv;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < i; j++) sd[j] <= '0;
          sv <= '0;
        end else begin
          sd[0] <= push_data[i*DW +: DW];
          sv[0] <= push_v;
          for (int j = 1; j < i; j++) begin
            sd[j] <= sd[j-1];
            sv[j] <= sv[j-1];
          end
        end
      end

      assign feed_d = sd[i-1];
      assign feed_v = sv[i-1];
    end

    // Lanes without real data are gated to zero so the PEs accumulate nothing.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_d <= '0;
        out_v <= 1'b0;
      end else begin
        out_d <= feed_v ? feed_d : '0;
        out_v <= feed_v;
      end
    end

    assign row_out[i*DW +: DW] = out_d;
    assign lane_valid[i]       = out_v;
  end

`ifdef SKEW_FEEDER_TILE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_count <= '0;
      last_k     <= '0;
    end else if (done_nxt) begin
      tile_count <= tile_count + 16'd1;
      last_k     <= k_reg;
    end
  end
`endif

endmodule
